mux_dest_arb: RTL and testbench
===============================

Name: mux_dest_arb

Overview:
- N-channel successor of the two-VC destination mux. It selects one word per cycle from NUM_VC virtual-channel sources and registers it toward the destination.
- Arbitration is fixed priority (lowest VC index wins) or round-robin, chosen by a mode input.
- It pops the winning source FIFO, honours destination back-pressure, and keeps a saturating count of forwarded words.
- Sits between the VC FIFOs and the destination port.

Parameters:
- BITNUMBER, 6: data word width.
- NUM_VC, 4: number of virtual-channel inputs; legal range is 2 or more.
- VC_W, 2: width of the channel index. Must satisfy 2^VC_W >= NUM_VC.
- COUNT_W, 8: width of the forwarded-word counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- data_in  in  NUM_VC*BITNUMBER  flattened VC data; VC i occupies bits [i*BITNUMBER +: BITNUMBER].
- valid_in  in  NUM_VC  bit i high means VC i has a word at its head.
- pause_dest  in  1  destination full; high blocks forwarding.
- mode_rr  in  1  0 = fixed priority, 1 = round-robin.
- pop_out  out  NUM_VC  combinational one-hot pop to the granted VC FIFO.
- valid_out_dest  out  1  registered valid for data_out_dest.
- data_out_dest  out  BITNUMBER  registered output word.
- grant_vc  out  VC_W  registered index of the VC that produced the current output.
- words_sent  out  COUNT_W  saturating count of forwarded words.

Behaviour:
- Reset, sampled on a clk edge with reset=0:
  - valid_out_dest=0, data_out_dest=0, grant_vc=0, words_sent=0.
  - Internal rr_ptr=0.
  - pop_out is forced to 0 for as long as reset=0.
- Grant logic (combinational):
  - A grant exists only when reset=1, pause_dest=0 and valid_in is nonzero.
  - Fixed mode: g = lowest i with valid_in[i]=1.
  - RR mode: g = first i with valid_in[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping NUM_VC-1 to 0.
  - pop_out[g]=1 in the same cycle; all other pop_out bits are 0.
  - pop_out is never multi-hot.
- Latency: one cycle. A word granted in cycle n appears on data_out_dest/valid_out_dest after the edge ending cycle n.
- On a grant at the edge:
  - data_out_dest <= data_in[g]; valid_out_dest <= 1; grant_vc <= g.
  - rr_ptr <= g+1, wrapping to 0 when g = NUM_VC-1. rr_ptr updates in both modes.
  - words_sent <= words_sent+1, saturating at all-ones (no wrap).
- No valid input and pause_dest=0: valid_out_dest <= 0, data_out_dest <= 0. grant_vc, rr_ptr and words_sent hold.
- pause_dest=1:
  - pop_out=0 and valid_out_dest <= 0.
  - data_out_dest, grant_vc, rr_ptr and words_sent hold.
  - pause takes priority over any valid input.
- mode_rr may change in any cycle and takes effect in that same cycle's grant. rr_ptr is preserved across mode changes.
- Simultaneous valids:
  - Fixed mode: starvation of higher indices is permitted.
  - RR mode: a VC continuously asserting valid is granted within NUM_VC grants.
- Reset mid-operation: any in-flight output word is discarded, the counter clears, and RR restarts at VC0. No pop is issued in the reset cycle.
- Flattened input slices outside NUM_VC do not exist. The block does not check X/Z on unselected channels.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all valid_in=1 -> pop_out=0 throughout; all outputs 0; after release, the first grant is VC0.
- Fixed priority (NUM_VC=4): valid_in=4'b1010, data VC1=6'h11, VC3=6'h33, mode_rr=0, for 3 cycles -> pop_out=4'b0010 each cycle; data_out_dest=6'h11, grant_vc=1 one cycle later; words_sent=3.
- Round-robin: valid_in=4'b1111, data VCi = i+1, mode_rr=1, for 6 cycles -> grant_vc sequence 0,1,2,3,0,1; data_out_dest 1,2,3,4,1,2.
- Back-pressure: RR stream as above, pause_dest=1 for 2 cycles after the grant of VC1 ->
  - pop_out=0 and valid_out_dest=0 during the pause.
  - data_out_dest holds 2 and words_sent holds.
  - Next grant after release is VC2.
- Idle: valid_in=0 for 2 cycles -> valid_out_dest=0, data_out_dest=0, counter unchanged.
- Saturation with mode switch: COUNT_W=4, 20 continuous grants, mode_rr toggled at grant 10 -> words_sent stops at 4'hF; grants continue normally across the mode change.

Source files
------------

// File: rtl/mux_dest_arb_if.sv
// Bus bundle between the VC FIFOs, the destination mux and the destination port.
interface mux_dest_arb_if #(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned VC_W      = 2,
  parameter int unsigned COUNT_W   = 8
) ();

  logic [NUM_VC*BITNUMBER-1:0] data_in;
  logic [NUM_VC-1:0]           valid_in;
  logic                        pause_dest;
  logic                        mode_rr;
  logic [NUM_VC-1:0]           pop_out;
  logic                        valid_out_dest;
  logic [BITNUMBER-1:0]        data_out_dest;
  logic [VC_W-1:0]             grant_vc;
  logic [COUNT_W-1:0]          words_sent;

  // Arbiter side: consumes VC heads and destination status, drives pops and the output word.
  modport master (
    input  data_in,
    input  valid_in,
    input  pause_dest,
    input  mode_rr,
    output pop_out,
    output valid_out_dest,
    output data_out_dest,
    output grant_vc,
    output words_sent
  );

  // Environment side: VC FIFOs and destination port.
  modport slave (
    output data_in,
    output valid_in,
    output pause_dest,
    output mode_rr,
    input  pop_out,
    input  valid_out_dest,
    input  data_out_dest,
    input  grant_vc,
    input  words_sent
  );

endinterface

// File: rtl/mux_dest_arb.sv
// N-channel destination mux: fixed-priority or round-robin selection of one VC word
// per cycle, registered toward the destination, with a saturating forwarded-word count.
module mux_dest_arb #(
  parameter int unsigned BITNUMBER = 6,
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned VC_W      = 2,
  parameter int unsigned COUNT_W   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mux_dest_arb_if.master bus
);

  logic [BITNUMBER-1:0] vc_data [NUM_VC];

  logic                 grant_c;
  logic [VC_W-1:0]      grant_idx_c;
  logic [BITNUMBER-1:0] grant_data_c;
  logic [NUM_VC-1:0]    pop_c;

  logic                 valid_out_q, valid_out_d;
  logic [BITNUMBER-1:0] data_out_q,  data_out_d;
  logic [VC_W-1:0]      grant_vc_q,  grant_vc_d;
  logic [VC_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [COUNT_W-1:0]   words_q,     words_d;

  // Unpack the flattened VC data bus into per-channel words.
  for (genvar gi = 0; gi < int'(NUM_VC); gi++) begin : g_unpack
    assign vc_data[gi] = bus.data_in[gi*BITNUMBER +: BITNUMBER];
  end

  // Grant selection: pick the valid VC with the smallest search distance.
  // Fixed mode measures distance from VC0; RR mode from rr_ptr with wrap.
  always_comb begin
    int unsigned dist_v;
    int unsigned best_v;
    grant_c      = 1'b0;
    grant_idx_c  = '0;
    grant_data_c = '0;
    best_v       = NUM_VC;
    dist_v       = 0;
    if (reset && !bus.pause_dest) begin
      for (int i = 0; i < int'(NUM_VC); i++) begin
        if (!bus.mode_rr) begin
          dist_v = 32'(i);
        end else if (32'(i) >= 32'(rr_ptr_q)) begin
          dist_v = 32'(i) - 32'(rr_ptr_q);
        end else begin
          dist_v = 32'(i) + NUM_VC - 32'(rr_ptr_q);
        end
        if (bus.valid_in[i] && (dist_v < best_v)) begin
          best_v       = dist_v;
          grant_c      = 1'b1;
          grant_idx_c  = VC_W'(i);
          grant_data_c = vc_data[i];
        end
      end
    end
  end

  // One-hot pop toward the granted VC FIFO; zero whenever there is no grant.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < int'(NUM_VC); i++) begin
      pop_c[i] = grant_c && (grant_idx_c == VC_W'(i));
    end
  end

  // Next-state for the output register, pointer and counter.
  always_comb begin
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    grant_vc_d  = grant_vc_q;
    rr_ptr_d    = rr_ptr_q;
    words_d     = words_q;
    if (grant_c) begin
      valid_out_d = 1'b1;
      data_out_d  = grant_data_c;
      grant_vc_d  = grant_idx_c;
      rr_ptr_d    = (grant_idx_c == VC_W'(NUM_VC - 1)) ? '0 : grant_idx_c + VC_W'(1);
      words_d     = (words_q == '1) ? words_q : words_q + COUNT_W'(1);
    end else if (!bus.pause_dest) begin
      // Idle cycle: the output word is cleared, everything else holds.
      data_out_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      grant_vc_q  <= '0;
      rr_ptr_q    <= '0;
      words_q     <= '0;
    end else begin
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      grant_vc_q  <= grant_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      words_q     <= words_d;
    end
  end

  assign bus.pop_out        = pop_c;
  assign bus.valid_out_dest = valid_out_q;
  assign bus.data_out_dest  = data_out_q;
  assign bus.grant_vc       = grant_vc_q;
  assign bus.words_sent     = words_q;

endmodule

// File: tb/tb_mux_dest_arb.sv
// Directed bench for mux_dest_arb: one 8-bit-counter instance and one 4-bit-counter
// instance share the same stimulus.
module tb_mux_dest_arb;

  logic        clk;
  logic        reset;
  logic [23:0] data_in;
  logic [3:0]  valid_in;
  logic        pause_dest;
  logic        mode_rr;

  int n_checks = 0;
  int n_errors = 0;

  mux_dest_arb_if #(.BITNUMBER(6), .NUM_VC(4), .VC_W(2), .COUNT_W(8)) bus  ();
  mux_dest_arb_if #(.BITNUMBER(6), .NUM_VC(4), .VC_W(2), .COUNT_W(4)) bus4 ();

  assign bus.data_in     = data_in;
  assign bus.valid_in    = valid_in;
  assign bus.pause_dest  = pause_dest;
  assign bus.mode_rr     = mode_rr;
  assign bus4.data_in    = data_in;
  assign bus4.valid_in   = valid_in;
  assign bus4.pause_dest = pause_dest;
  assign bus4.mode_rr    = mode_rr;

  mux_dest_arb #(.BITNUMBER(6), .NUM_VC(4), .VC_W(2), .COUNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  mux_dest_arb #(.BITNUMBER(6), .NUM_VC(4), .VC_W(2), .COUNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack4(input logic [5:0] d0, input logic [5:0] d1,
                                        input logic [5:0] d2, input logic [5:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int w4;

    // Reset held for two edges with every VC valid
    reset      = 1'b0;
    valid_in   = 4'b1111;
    data_in    = pack4(6'd1, 6'd2, 6'd3, 6'd4);
    pause_dest = 1'b0;
    mode_rr    = 1'b0;
    #1;
    chk("rst_pop_a", 32'(bus.pop_out), 32'h0);
    tick();
    chk("rst_pop_b", 32'(bus.pop_out), 32'h0);
    tick();
    chk("rst_pop_c",   32'(bus.pop_out), 32'h0);
    chk("rst_valid",   32'(bus.valid_out_dest), 32'h0);
    chk("rst_data",    32'(bus.data_out_dest), 32'h0);
    chk("rst_grant",   32'(bus.grant_vc), 32'h0);
    chk("rst_words",   32'(bus.words_sent), 32'h0);
    chk("rst_words4",  32'(bus4.words_sent), 32'h0);

    // First grant after release goes to VC0
    reset = 1'b1;
    #1;
    chk("first_pop", 32'(bus.pop_out), 32'h1);
    tick();
    chk("first_grant", 32'(bus.grant_vc), 32'h0);
    chk("first_data",  32'(bus.data_out_dest), 32'h1);
    chk("first_valid", 32'(bus.valid_out_dest), 32'h1);
    chk("first_words", 32'(bus.words_sent), 32'h1);

    // Fixed priority with VC1 and VC3 valid: VC1 always wins
    valid_in = 4'b1010;
    data_in  = pack4(6'h00, 6'h11, 6'h22, 6'h33);
    mode_rr  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("fix_pop%0d", c), 32'(bus.pop_out), 32'b0010);
      tick();
      chk($sformatf("fix_data%0d", c),  32'(bus.data_out_dest), 32'h11);
      chk($sformatf("fix_grant%0d", c), 32'(bus.grant_vc), 32'h1);
      chk($sformatf("fix_words%0d", c), 32'(bus.words_sent), 32'(2 + c));
    end

    // Mid-operation reset: no pop, outputs and counter cleared
    reset = 1'b0;
    #1;
    chk("mid_rst_pop", 32'(bus.pop_out), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(bus.valid_out_dest), 32'h0);
    chk("mid_rst_data",  32'(bus.data_out_dest), 32'h0);
    chk("mid_rst_grant", 32'(bus.grant_vc), 32'h0);
    chk("mid_rst_words", 32'(bus.words_sent), 32'h0);

    // Round-robin over four always-valid VCs: 0,1,2,3,0,1
    reset    = 1'b1;
    valid_in = 4'b1111;
    data_in  = pack4(6'd1, 6'd2, 6'd3, 6'd4);
    mode_rr  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      g = c % 4;
      #1;
      chk($sformatf("rr_pop%0d", c), 32'(bus.pop_out), 32'(1) << g);
      tick();
      chk($sformatf("rr_grant%0d", c), 32'(bus.grant_vc), 32'(g));
      chk($sformatf("rr_data%0d", c),  32'(bus.data_out_dest), 32'(g + 1));
      chk($sformatf("rr_words%0d", c), 32'(bus.words_sent), 32'(c + 1));
    end

    // Back-pressure for two cycles after the VC1 grant
    pause_dest = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("pause_pop%0d", c), 32'(bus.pop_out), 32'h0);
      tick();
      chk($sformatf("pause_valid%0d", c), 32'(bus.valid_out_dest), 32'h0);
      chk($sformatf("pause_data%0d", c),  32'(bus.data_out_dest), 32'h2);
      chk($sformatf("pause_grant%0d", c), 32'(bus.grant_vc), 32'h1);
      chk($sformatf("pause_words%0d", c), 32'(bus.words_sent), 32'd6);
    end
    pause_dest = 1'b0;
    #1;
    chk("resume_pop", 32'(bus.pop_out), 32'b0100);
    tick();
    chk("resume_grant", 32'(bus.grant_vc), 32'h2);
    chk("resume_data",  32'(bus.data_out_dest), 32'h3);
    chk("resume_valid", 32'(bus.valid_out_dest), 32'h1);
    chk("resume_words", 32'(bus.words_sent), 32'd7);

    // Idle: no valid input for two cycles
    valid_in = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("idle_pop%0d", c), 32'(bus.pop_out), 32'h0);
      tick();
      chk($sformatf("idle_valid%0d", c), 32'(bus.valid_out_dest), 32'h0);
      chk($sformatf("idle_data%0d", c),  32'(bus.data_out_dest), 32'h0);
      chk($sformatf("idle_grant%0d", c), 32'(bus.grant_vc), 32'h2);
      chk($sformatf("idle_words%0d", c), 32'(bus.words_sent), 32'd7);
    end

    // Saturation on the 4-bit counter, switching RR -> fixed at grant 10
    reset = 1'b0;
    tick();
    chk("sat_rst_words4", 32'(bus4.words_sent), 32'h0);
    reset    = 1'b1;
    valid_in = 4'b1111;
    mode_rr  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) mode_rr = 1'b0;
      g  = (c < 10) ? (c % 4) : 0;
      w4 = (c + 1 > 15) ? 15 : c + 1;
      tick();
      chk($sformatf("sat_grant%0d", c),  32'(bus4.grant_vc), 32'(g));
      chk($sformatf("sat_data%0d", c),   32'(bus4.data_out_dest), 32'(g + 1));
      chk($sformatf("sat_words4_%0d", c), 32'(bus4.words_sent), 32'(w4));
      chk($sformatf("sat_words8_%0d", c), 32'(bus.words_sent), 32'(c + 1));
    end

    // Back to RR: pointer kept advancing in fixed mode, so VC1 is next
    mode_rr = 1'b1;
    #1;
    chk("rr_again_pop", 32'(bus.pop_out), 32'b0010);
    tick();
    chk("rr_again_grant",  32'(bus4.grant_vc), 32'h1);
    chk("rr_again_words4", 32'(bus4.words_sent), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
